// File: rtl/fp_add_issuer.sv
// Operand-side issuer for the adder datapath: queues operand pairs, issues one at a
// time with a Go pulse, captures the sum on FlagResult and flags a missing response.
module fp_add_issuer #(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23,
  parameter int DEPTH        = 4,
  parameter int TIMEOUT      = 64,
  localparam int W           = 1 + EXPBITS + MANTISSABITS
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_operand_a,
  input  logic [W-1:0] i_operand_b,
  output logic         o_go,
  output logic [W-1:0] o_add_a,
  output logic [W-1:0] o_add_b,
  input  logic         i_flag_result,
  input  logic [W-1:0] i_add_result,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_result,
  output logic         o_busy,
  output logic         o_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [W-1:0]   r_fifo_a [DEPTH];
  logic [W-1:0]   r_fifo_b [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [TW-1:0]  r_tcnt;
  logic           r_go, r_out_valid, r_error;
  logic [W-1:0]   r_add_a, r_add_b, r_result;

  logic w_push, w_pop, w_empty, w_capture, w_timeout, w_flag_err;

  // Ready ignores a same-cycle pop: a full FIFO never passes data through.
  assign o_in_ready = (r_count < CW'(DEPTH)) && !i_rst;
  assign w_push     = i_in_valid && o_in_ready;
  assign w_empty    = (r_count == '0);
  assign o_busy     = (r_state != S_IDLE) || !w_empty;
  assign w_flag_err = i_flag_result && (r_state != S_WAIT);

  assign o_go        = r_go;
  assign o_add_a     = r_add_a;
  assign o_add_b     = r_add_b;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_error     = r_error;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_next = S_ISSUE;
          w_pop  = 1'b1;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        // The counter's next value hitting TIMEOUT-1 puts the abort TIMEOUT edges after Go.
        if (i_flag_result) begin
          w_next    = S_DONE;
          w_capture = 1'b1;
        end else if (r_tcnt == TW'(TIMEOUT - 2)) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      S_DONE: begin
        if (r_out_valid && i_out_ready) begin
          if (!w_empty) begin
            w_next = S_ISSUE;
            w_pop  = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr] <= i_operand_a;
      r_fifo_b[r_wr_ptr] <= i_operand_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_tcnt      <= '0;
      r_go        <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_add_a  <= r_fifo_a[r_rd_ptr];
        r_add_b  <= r_fifo_b[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_go    <= w_pop;

      if (r_state == S_ISSUE)     r_tcnt <= '0;
      else if (r_state == S_WAIT) r_tcnt <= r_tcnt + TW'(1);

      if (w_capture) begin
        r_result    <= i_add_result;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_flag_err || w_timeout) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_add_issuer.sv
// Randomized bench for fp_add_issuer against a transaction-level queue model.
module tb_fp_add_issuer;
  localparam int W       = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, flag = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0, add_res = '0;
  logic         in_ready, go, out_valid, busy, error;
  logic [W-1:0] add_a, add_b, result;

  always #5 clk = ~clk;

  fp_add_issuer #(.EXPBITS(8), .MANTISSABITS(23), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_operand_a(a), .i_operand_b(b), .o_go(go), .o_add_a(add_a), .o_add_b(add_b),
    .i_flag_result(flag), .i_add_result(add_res), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_result(result), .o_busy(busy), .o_error(error)
  );

  int n_vec = 0, n_bad = 0;

  // model: pending pairs, op in flight (with age), result held downstream
  logic [2*W-1:0] q[$];
  bit           m_inflight = 0, m_holding = 0, m_go = 0, m_err = 0;
  int           m_wcnt = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;

  bit auto_adder = 0, adr_pending = 0;
  int adr_cnt = 0, p_valid = 0, p_ready = 0;

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    bit push, pop, hs;
    logic [2*W-1:0] e;
    hs   = m_holding && out_ready;
    pop  = !rst && q.size() > 0 && !m_inflight && (!m_holding || hs);
    push = !rst && in_valid && q.size() < DEPTH;
    @(posedge clk); #1;
    if (rst) begin
      q.delete();
      m_inflight = 0; m_holding = 0; m_go = 0; m_err = 0;
      m_a = '0; m_b = '0; m_res = '0; adr_pending = 0;
    end else begin
      m_go = 0;
      if (hs) m_holding = 0;
      if (m_inflight) begin
        if (flag && m_wcnt > 0) begin
          m_inflight = 0; m_holding = 1; m_res = add_res;
        end else begin
          if (flag) m_err = 1;
          m_wcnt++;
          if (m_wcnt == TIMEOUT) begin m_inflight = 0; m_err = 1; end
        end
      end else if (flag) m_err = 1;
      if (pop) begin
        e = q.pop_front();
        m_a = e[2*W-1:W]; m_b = e[W-1:0];
        m_inflight = 1; m_wcnt = 0; m_go = 1;
      end
      if (push) q.push_back({a, b});
    end
    chk("go", go, m_go);
    chk("add_a", add_a, m_a);
    chk("add_b", add_b, m_b);
    chk("out_valid", out_valid, m_holding);
    chk("result", result, m_res);
    chk("error", error, m_err);
    chk("busy", busy, (q.size() > 0 || m_inflight || m_holding));
    chk("in_ready", in_ready, (!rst && q.size() < DEPTH));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(99) < p_valid);
      a         = $urandom;
      b         = $urandom;
      out_ready = ($urandom_range(99) < p_ready);
      flag      = 1'b0;
      if (auto_adder && adr_pending) begin
        adr_cnt--;
        if (adr_cnt == 0) begin
          flag = 1'b1; add_res = $urandom; adr_pending = 0;
        end
      end
      cycle();
      if (m_go) begin adr_pending = 1; adr_cnt = $urandom_range(2, 7); end
    end
    in_valid = 1'b0;
    flag     = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    chk("rst_release_inready", in_ready, 1'b1);

    // single op with exact latency
    in_valid = 1'b1; a = 32'h3F800000; b = 32'h40000000;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("single_go", go, 1'b1);
    chk("single_add_a", add_a, 32'h3F800000);
    chk("single_add_b", add_b, 32'h40000000);
    repeat (4) cycle();
    flag = 1'b1; add_res = 32'h40400000;
    cycle();
    flag = 1'b0;
    chk("single_ov", out_valid, 1'b1);
    chk("single_res", result, 32'h40400000);
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("single_busy", busy, 1'b0);
    chk("single_err", error, 1'b0);

    // fill the FIFO with the adder stalled, then drain in order
    p_ready = 100; p_valid = 100; auto_adder = 0;
    run(6);
    chk("fill_inready", in_ready, 1'b0);
    p_valid = 0; auto_adder = 1;
    run(60);

    // downstream backpressure holds the result and blocks the next Go
    p_ready = 0; p_valid = 100;
    run(2);
    p_valid = 0;
    run(20);
    chk("bp_ov", out_valid, 1'b1);
    p_ready = 100;
    run(1);
    chk("bp_go", go, 1'b1);
    run(20);

    // random traffic
    p_valid = 50; p_ready = 60;
    run(400);
    p_valid = 0; p_ready = 100;
    run(40);
    chk("rand_err", error, 1'b0);

    // reset with one op waiting and two queued
    p_valid = 100; auto_adder = 0;
    run(3);
    p_valid = 0;
    run(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rstmid_inready", in_ready, 1'b1);
    run(5);
    chk("rstmid_go", go, 1'b0);

    // spurious FlagResult in IDLE
    flag = 1'b1; add_res = 32'hDEADBEEF;
    cycle();
    flag = 1'b0;
    chk("spur_err", error, 1'b1);
    cycle();
    chk("spur_sticky", error, 1'b1);
    chk("spur_res", result, 32'h0);

    // timeouts: two queued ops, adder never answers
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    p_valid = 100; auto_adder = 0;
    run(2);
    p_valid = 0;
    run(2 * TIMEOUT + 10);
    adr_pending = 0;
    chk("to_err", error, 1'b1);
    flag = 1'b1; add_res = 32'h12345678;
    cycle();
    flag = 1'b0;
    cycle();
    chk("to_ov", out_valid, 1'b0);
    chk("to_res", result, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
